// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequenced single-precision divider.
// Operand classification lives here so the bench-facing top and the special-case logic agree.
package fp_div_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OF  = 1;
  localparam int FLG_UF  = 0;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_e;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} opclass_e;

  // Exponent zero is treated as zero regardless of mantissa: denormals are flushed.
  function automatic opclass_e classify(input logic [31:0] x);
    if (x[EXP_W+MAN_W-1:MAN_W] == '0) begin
      return ZERO;
    end else if (x[EXP_W+MAN_W-1:MAN_W] == '1) begin
      return (x[MAN_W-1:0] == '0) ? INF : NAN;
    end else begin
      return NORMAL;
    end
  endfunction

endpackage

// File: rtl/fp_div_sequencer_if.sv
// Operand/result handshake bundle between the FP issue logic and the divide sequencer.
interface fp_div_sequencer_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags, busy
  );

endinterface

// File: rtl/fp_div_special.sv
// Combinational special-operand detection for the divider.
// When special_o is high the quotient is fully determined without running the mantissa divide.
module fp_div_special
  import fp_div_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        special_o,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);

  opclass_e classA;
  opclass_e classB;
  logic     sign;

  assign classA = classify(a_i);
  assign classB = classify(b_i);
  assign sign   = a_i[31] ^ b_i[31];

  // Priority order matters: invalid cases must win over the inf/zero shortcuts below them.
  always_comb begin
    special_o = 1'b1;
    result_o  = '0;
    flags_o   = '0;
    if (classA == NAN || classB == NAN ||
        (classA == ZERO && classB == ZERO) ||
        (classA == INF && classB == INF)) begin
      result_o         = QNAN;
      flags_o[FLG_INV] = 1'b1;
    end else if (classA == INF) begin
      result_o = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (classB == INF) begin
      result_o = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (classB == ZERO) begin
      result_o        = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLG_DZ] = 1'b1;
    end else if (classA == ZERO) begin
      result_o = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      special_o = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_sequencer.sv
// Multi-cycle IEEE-754 single-precision divider: restoring divide at one quotient bit per
// clock, then a single normalise/pack cycle. Results are truncated, denormals flushed.
module fp_div_sequencer
  import fp_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fp_div_sequencer_if.slave   bus
);

  state_e             state_q,  state_d;
  logic [MAN_W+1:0]   rem_q,    rem_d;
  logic [MAN_W:0]     div_q,    div_d;
  logic [MAN_W+1:0]   quo_q,    quo_d;
  logic [4:0]         cnt_q,    cnt_d;
  logic               sign_q,   sign_d;
  logic [EXP_W-1:0]   ea_q,     ea_d;
  logic [EXP_W-1:0]   eb_q,     eb_d;
  logic [31:0]        result_q, result_d;
  logic [3:0]         flags_q,  flags_d;

  logic               specHit;
  logic [31:0]        specResult;
  logic [3:0]         specFlags;

  fp_div_special u_special (
    .a_i       (bus.in_a),
    .b_i       (bus.in_b),
    .special_o (specHit),
    .result_o  (specResult),
    .flags_o   (specFlags)
  );

  // A quotient below 1.0 drops its top bit, so take one more fraction bit and borrow from the exponent.
  logic                    cdNorm;
  logic [MAN_W-1:0]        mantNorm;
  logic signed [EXP_W+1:0] expNorm;
  logic                    expOver;
  logic                    expUnder;

  assign cdNorm   = ~quo_q[MAN_W+1];
  assign mantNorm = cdNorm ? quo_q[MAN_W-1:0] : quo_q[MAN_W:1];
  assign expNorm  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                  + $signed((EXP_W+2)'(BIAS))
                  - $signed({{(EXP_W+1){1'b0}}, cdNorm});
  assign expOver  = expNorm >= $signed((EXP_W+2)'((1 << EXP_W) - 1));
  assign expUnder = expNorm[EXP_W+1] || (expNorm == '0);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_a[31] ^ bus.in_b[31];
          ea_d   = bus.in_a[EXP_W+MAN_W-1:MAN_W];
          eb_d   = bus.in_b[EXP_W+MAN_W-1:MAN_W];
          if (specHit) begin
            result_d = specResult;
            flags_d  = specFlags;
            state_d  = DONE;
          end else begin
            rem_d   = {1'b0, 1'b1, bus.in_a[MAN_W-1:0]};
            div_d   = {1'b1, bus.in_b[MAN_W-1:0]};
            quo_d   = '0;
            cnt_d   = 5'(MAN_W + 1);
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (rem_q >= {1'b0, div_q}) begin
          rem_d = (rem_q - {1'b0, div_q}) << 1;
          quo_d = {quo_q[MAN_W:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          quo_d = {quo_q[MAN_W:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) begin
          state_d = NORM;
        end
      end
      NORM: begin
        flags_d = '0;
        if (expOver) begin
          result_d        = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[FLG_OF] = 1'b1;
        end else if (expUnder) begin
          result_d        = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          flags_d[FLG_UF] = 1'b1;
        end else begin
          result_d = {sign_q, expNorm[EXP_W-1:0], mantNorm};
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed plus randomised bench for fp_div_sequencer using a result scoreboard.
module tb_fp_div_sequencer;

  logic clk;
  logic rst_n;

  fp_div_sequencer_if bus ();

  fp_div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer quotient of the significands, truncated, with the same exponent rule.
  function automatic logic [35:0] modelDiv(input logic [31:0] a, input logic [31:0] b);
    longint unsigned num, den, q;
    int              e;
    logic [22:0]     mant;
    logic [3:0]      fl;
    logic [31:0]     r;
    logic            s;
    s   = a[31] ^ b[31];
    num = (longint'(a[22:0]) | (64'd1 << 23)) << 24;
    den = longint'(b[22:0]) | (64'd1 << 23);
    q   = num / den;
    if (q[24]) begin
      mant = q[23:1];
      e    = int'(a[30:23]) - int'(b[30:23]) + 127;
    end else begin
      mant = q[22:0];
      e    = int'(a[30:23]) - int'(b[30:23]) + 126;
    end
    fl = 4'b0000;
    if (e >= 255) begin
      r  = {s, 8'hFF, 23'd0};
      fl = 4'b0010;
    end else if (e <= 0) begin
      r  = {s, 31'd0};
      fl = 4'b0001;
    end else begin
      r = {s, 8'(e), mant};
    end
    return {fl, r};
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, bus.out_result, e.res);
    check({tag, "_flags"}, 32'(bus.out_flags), 32'(e.flags));
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] flags, input int lat);
    int l;
    sb.push_back('{res: res, flags: flags, lat: lat});
    applyStimulus(a, b);
    waitResult(l);
    checkOutput(tag, l);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_result"}, bus.out_result, 32'd0);
    check({tag, "_out_flags"}, 32'(bus.out_flags), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [35:0] m;
    logic [31:0] held;
    int          l;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    #1;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed normal operands");
    runOp("div_6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    runOp("div_1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27);
    runOp("overflow",  32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010, 27);
    runOp("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27);
    runOp("neg_6_2",   32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 27);

    $display("[TB] special operands");
    runOp("x_div_0",   32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
    runOp("0_div_0",   32'h80000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    runOp("x_div_inf", 32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 1);
    runOp("nan_in",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
    runOp("inf_div_x", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    runOp("inf_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1);
    runOp("0_div_x",   32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000, 1);

    $display("[TB] random normal operands");
    for (int i = 0; i < 4; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      m  = modelDiv(ra, rb);
      runOp($sformatf("rand%0d", i), ra, rb, m[31:0], m[35:32], 27);
    end

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    sb.push_back('{res: 32'h40400000, flags: 4'b0000, lat: 27});
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResult(l);
    held = bus.out_result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_a     = 32'h3F800000;
      bus.in_b     = 32'h40400000;
      bus.in_valid = 1'b1;
      check($sformatf("bp_hold%0d_result", i), bus.out_result, held);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    checkOutput("bp_first", l);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back('{res: 32'h3EAAAAAA, flags: 4'b0000, lat: 27});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waitResult(l);
    checkOutput("bp_second", l);

    $display("[TB] reset mid-divide");
    applyStimulus(32'h40C00000, 32'h40000000);
    repeat (11) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_result", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
